// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding async_transmitter: buffers host bytes and launches one
// TxD_start pulse per byte whenever the transmitter reports idle.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic          TxD_start,
  output logic [7:0]    TxD_data,
  input  logic          TxD_busy,
  output logic          tx_done,
  output logic [1:0]    state_dbg
);

  // Handshake: a byte is taken on any edge with wr_en=1 and full=0; the
  // transmitter takes TxD_data on the single edge where TxD_start=1.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  state_t        state_q;
  logic          start_q, done_q;
  logic [7:0]    data_q;
  logic          wr_ok, wr_drop, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign TxD_start = start_q;
  assign TxD_data  = data_q;
  assign tx_done   = done_q;
  assign state_dbg = state_q;

  always_comb begin
    wr_ok      = wr_en && !full;
    wr_drop    = wr_en && full;
    do_pop     = (state_q == S_IDLE) && !empty && !TxD_busy;
    wr_ptr_d   = wr_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({wr_ok, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A dropped write outranks a clear in the same cycle.
    overflow_d = overflow_q;
    if (wr_drop)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (do_pop) begin
            start_q <= 1'b1;
            data_q  <= mem_q[rd_ptr_q];
            state_q <= S_LAUNCH;
          end
        end
        // Transmitter samples start on this edge; busy is only valid after it.
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (!TxD_busy) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: transmitter model, queue-based reference model with
// per-cycle compare, and directed scenarios with literal expectations.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst, wr_en, clr_overflow;
  logic [7:0]    wr_data;
  logic          full, empty, overflow, tx_start, tx_done;
  logic [AW:0]   count;
  logic [7:0]    tx_data;
  logic [1:0]    state_dbg;
  logic          busy_hold, frame_busy;
  wire           tx_busy;
  assign tx_busy = busy_hold | frame_busy;

  int checks = 0, failures = 0, cyc = 0;
  int frame_len = 4;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow), .TxD_start(tx_start), .TxD_data(tx_data),
    .TxD_busy(tx_busy), .tx_done(tx_done), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter: busy rises the cycle after it samples start, lasts frame_len cycles.
  initial begin
    int left;
    bit armed;
    left = 0; armed = 0; frame_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (armed) begin
        frame_busy = 1'b1; left = frame_len; armed = 0;
      end else if (left > 0) begin
        left--;
        if (left == 0) frame_busy = 1'b0;
      end
      if (tx_start === 1'b1 && !frame_busy) armed = 1;
    end
  end

  // Reference model: FIFO contents plus an outstanding-frame tracker.
  logic [7:0] exp_q[$];
  logic [7:0] in_log[$], out_log[$];
  int         start_edges[$], done_edges[$];
  bit         m_ovf, m_start, m_done, m_frame;
  logic [7:0] m_data;
  int         m_age, n_start, n_done;

  initial begin
    bit s_rst, s_wr, s_clr, s_busy, launch;
    logic [7:0] s_d;
    int pre;
    m_ovf = 0; m_start = 0; m_done = 0; m_frame = 0; m_data = 8'h00; m_age = 0;
    n_start = 0; n_done = 0;
    forever begin
      @(posedge clk);
      cyc++;
      s_rst = rst; s_wr = wr_en; s_clr = clr_overflow; s_busy = tx_busy; s_d = wr_data;
      if (s_rst) begin
        exp_q.delete();
        m_ovf = 0; m_start = 0; m_done = 0; m_frame = 0; m_data = 8'h00; m_age = 0;
      end else begin
        pre    = exp_q.size();
        launch = !m_frame && pre > 0 && !s_busy;
        m_done = 0;
        if (m_frame) begin
          m_age++;
          if (m_age >= 2 && !s_busy) begin m_done = 1; m_frame = 0; end
        end
        m_start = launch;
        if (launch) begin
          m_data = exp_q.pop_front(); m_frame = 1; m_age = 0;
        end
        if (s_wr && pre == DEPTH) m_ovf = 1;
        else if (s_clr)           m_ovf = 0;
        if (s_wr && pre < DEPTH) begin
          exp_q.push_back(s_d); in_log.push_back(s_d);
        end
      end
      #1;
      chk("count",    count,    exp_q.size());
      chk("full",     full,     exp_q.size() == DEPTH);
      chk("empty",    empty,    exp_q.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("start",    tx_start, m_start);
      chk("data",     tx_data,  m_data);
      chk("done",     tx_done,  m_done);
      if (tx_start === 1'b1) begin out_log.push_back(tx_data); start_edges.push_back(cyc); n_start++; end
      if (tx_done === 1'b1)  begin done_edges.push_back(cyc); n_done++; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while ((exp_q.size() != 0 || m_frame || tx_busy) && k < max_cyc) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= max_cyc) begin
      failures++;
      $display("FAIL drain: timeout after %0d cycles, model holds %0d bytes", k, exp_q.size());
    end
  endtask

  task automatic clear_logs();
    in_log.delete(); out_log.delete(); start_edges.delete(); done_edges.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int s0, d0, w_edge, rel_edge, bad;
    logic [7:0] ov [17];
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0; busy_hold = 1'b0;
    step(3);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    step(2);

    // Single byte with an 11-bit-time frame (2 cycles per bit).
    frame_len = 22; clear_logs(); s0 = n_start; d0 = n_done;
    wr(8'h55); w_edge = cyc;
    drain(200);
    chk("t1_starts", n_start - s0, 1);
    chk("t1_start_edge", start_edges[0] - w_edge, 1);
    chk("t1_data", out_log[0], 8'h55);
    chk("t1_dones", n_done - d0, 1);
    chk("t1_empty", empty, 1);

    // Burst of 16 while busy, then release and check order and spacing.
    frame_len = 3; busy_hold = 1'b1; clear_logs();
    for (int i = 1; i <= 16; i++) wr(8'(i));
    chk("t2_count", count, 16);
    chk("t2_full", full, 1);
    busy_hold = 1'b0;
    drain(400);
    chk("t2_nout", out_log.size(), 16);
    bad = 0;
    for (int i = 0; i < 16 && i < out_log.size(); i++) if (out_log[i] != 8'(i + 1)) bad++;
    chk("t2_order", bad, 0);
    bad = 0;
    for (int k = 1; k < 16 && k < start_edges.size() && k <= done_edges.size(); k++)
      if (start_edges[k] != done_edges[k-1] + 1) bad++;
    chk("t2_gap", bad, 0);
    chk("t2_ndone", done_edges.size(), 16);

    // Overflow: 17 writes while busy, then clear with and without a dropped write.
    busy_hold = 1'b1; clear_logs();
    for (int i = 0; i < 17; i++) begin ov[i] = 8'($urandom_range(0, 255)); wr(ov[i]); end
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 1);
    wr_en = 1'b1; wr_data = 8'hEE; clr_overflow = 1'b1;
    step(1);
    wr_en = 1'b0; clr_overflow = 1'b0;
    chk("t3_ovf_set_wins", overflow, 1);
    clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    busy_hold = 1'b0;
    drain(400);
    chk("t3_nout", out_log.size(), 16);
    bad = 0;
    for (int i = 0; i < 16 && i < out_log.size(); i++) if (out_log[i] != ov[i]) bad++;
    chk("t3_order", bad, 0);

    // Write coinciding with the launch edge at count=3.
    busy_hold = 1'b1; clear_logs();
    wr(8'h11); wr(8'h22); wr(8'h33);
    busy_hold = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
    step(1);
    wr_en = 1'b0;
    chk("t4_count", count, 3);
    chk("t4_start", tx_start, 1);
    chk("t4_data", tx_data, 8'h11);
    drain(200);
    chk("t4_last", out_log[out_log.size()-1], 8'h77);

    // Random traffic, 40 bytes, pointers wrap twice.
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      frame_len = $urandom_range(1, 8);
      while (exp_q.size() == DEPTH) step(1);
      clr_overflow = ($urandom_range(0, 7) == 0);
      wr(8'($urandom));
      clr_overflow = 1'b0;
      step($urandom_range(0, 3));
    end
    drain(2000);
    chk("t5_nin", in_log.size(), 40);
    chk("t5_nout", out_log.size(), 40);
    bad = 0;
    for (int i = 0; i < 40 && i < out_log.size() && i < in_log.size(); i++)
      if (out_log[i] != in_log[i]) bad++;
    chk("t5_order", bad, 0);

    // Byte arriving while the transmitter is busy.
    frame_len = 4; busy_hold = 1'b1; clear_logs(); s0 = n_start;
    wr(8'hA5);
    step(5);
    chk("t6_no_start", n_start - s0, 0);
    busy_hold = 1'b0; rel_edge = cyc + 1;
    step(1);
    chk("t6_start", tx_start, 1);
    chk("t6_data", tx_data, 8'hA5);
    chk("t6_edge", (start_edges.size() > 0) ? start_edges[0] : -1, rel_edge);
    drain(200);

    // Reset during WAIT with 5 bytes queued.
    frame_len = 30; clear_logs();
    for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i));
    step(2);
    chk("t7_count_pre", count, 5);
    chk("t7_busy_pre", tx_busy, 1);
    d0 = n_done;
    rst = 1'b1; step(1); rst = 1'b0;
    chk("t7_count", count, 0);
    chk("t7_start", tx_start, 0);
    s0 = n_start;
    wr(8'h3C);
    step(3);
    chk("t7_no_start", n_start - s0, 0);
    drain(300);
    chk("t7_starts", n_start - s0, 1);
    chk("t7_data", out_log[out_log.size()-1], 8'h3C);
    chk("t7_dones", n_done - d0, 1);
    chk("t7_done_after", (done_edges.size() > 0) ? (done_edges[done_edges.size()-1] > start_edges[start_edges.size()-1]) : 0, 1);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
